// File: rtl/matrix_scan_ctrl.sv
// Column-scanning LED matrix controller with glyph ROM fetch, frame-step and scroll modes.
// Optional GHOST_BLANK_EN: blank the first output cycle of each column (needs SCAN_DIV >= 2).
module matrix_scan_ctrl #(
    parameter int COLS       = 16,
    parameter int ROW_W      = 16,
    parameter int NUM_FRAMES = 6,
    parameter int SCAN_DIV   = 1,
    parameter int HOLD_TICKS = 1,
    localparam int TOTAL = NUM_FRAMES * COLS,
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1,
    localparam int FW    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    localparam int DW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1,
    localparam int HW    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             mode,
    input  logic             pause,
    output logic [AW-1:0]    rom_addr,
    input  logic [ROW_W-1:0] rom_data,
    output logic [CW-1:0]    I_COL,
    output logic [ROW_W-1:0] I_ROW,
    output logic [FW-1:0]    frame_idx,
    output logic             frame_start
);

    logic [DW-1:0] div_cnt;
    logic [CW-1:0] col_cnt;
    logic [FW-1:0] frame;
    logic [AW-1:0] scroll_pos;
    logic [HW-1:0] hold_cnt;
    logic          pending;
    logic          mode_q;
    logic [CW-1:0] col_p1;
    logic          wrap_p1;
`ifdef GHOST_BLANK_EN
    logic          first_p1;
`endif

    logic          col_step;
    logic          frame_wrap;
    logic          tick_ok;
    logic          tick_full;
    logic [AW:0]   step_addr;
    logic [AW:0]   scroll_sum;
    logic [AW:0]   scroll_addr;
    logic [AW:0]   scroll_frame;

    assign col_step   = (div_cnt == DW'(SCAN_DIV - 1));
    assign frame_wrap = col_step && (col_cnt == CW'(COLS - 1));
    assign tick_ok    = tick && !pause;
    assign tick_full  = tick_ok && (hold_cnt == HW'(HOLD_TICKS - 1));

    // scroll_pos < TOTAL and col_cnt < COLS <= TOTAL, so one subtract suffices
    assign step_addr    = (AW+1)'(frame) * (AW+1)'(COLS) + (AW+1)'(col_cnt);
    assign scroll_sum   = {1'b0, scroll_pos} + (AW+1)'(col_cnt);
    assign scroll_addr  = (scroll_sum >= (AW+1)'(TOTAL)) ? scroll_sum - (AW+1)'(TOTAL) : scroll_sum;
    assign scroll_frame = {1'b0, scroll_pos} / (AW+1)'(COLS);

    assign rom_addr  = mode_q ? scroll_addr[AW-1:0] : step_addr[AW-1:0];
    assign frame_idx = mode_q ? FW'(scroll_frame) : frame;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            col_cnt    <= '0;
            frame      <= '0;
            scroll_pos <= '0;
            hold_cnt   <= '0;
            pending    <= 1'b0;
            mode_q     <= 1'b0;
        end else begin
            mode_q  <= mode;
            div_cnt <= col_step ? '0 : div_cnt + 1'b1;
            if (col_step)
                col_cnt <= (col_cnt == CW'(COLS - 1)) ? '0 : col_cnt + 1'b1;

            if (mode != mode_q) begin
                frame      <= '0;
                scroll_pos <= '0;
                hold_cnt   <= '0;
                pending    <= 1'b0;
            end else begin
                if (tick_ok)
                    hold_cnt <= tick_full ? '0 : hold_cnt + 1'b1;
                // advance only at the frame boundary so a frame is never torn
                if (frame_wrap && pending) begin
                    if (mode_q)
                        scroll_pos <= (scroll_pos == AW'(TOTAL - 1)) ? '0 : scroll_pos + 1'b1;
                    else
                        frame <= (frame == FW'(NUM_FRAMES - 1)) ? '0 : frame + 1'b1;
                end
                if (tick_full)
                    pending <= 1'b1;
                else if (frame_wrap)
                    pending <= 1'b0;
            end
        end
    end

    // rom_data arrives one edge after rom_addr, so column tags are delayed to match
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_p1      <= '0;
            wrap_p1     <= 1'b0;
            I_COL       <= '0;
            I_ROW       <= '0;
            frame_start <= 1'b0;
`ifdef GHOST_BLANK_EN
            first_p1    <= 1'b0;
`endif
        end else begin
            col_p1      <= col_cnt;
            wrap_p1     <= (col_cnt == '0) && (div_cnt == '0);
            I_COL       <= col_p1;
            frame_start <= wrap_p1;
`ifdef GHOST_BLANK_EN
            first_p1    <= (div_cnt == '0);
            I_ROW       <= ((SCAN_DIV >= 2) && first_p1) ? '0 : rom_data;
`else
            I_ROW       <= rom_data;
`endif
        end
    end

endmodule
